ma_stage: RTL and testbench
===========================

# ma_stage

Memory-access stage of the pipelined TinyRISC core, sitting between the EX/MA pipeline register and the MA/RW pipeline register. It issues loads and stores to a variable-latency data memory over a req/ack handshake. While an access is outstanding it holds the upstream pipeline with `stall` and feeds bubbles downstream. It flags misaligned accesses and memory timeouts with sticky error bits.

## Interface
Parameters:
- `ST_BIT`, 0, index of isSt in the control word
- `LD_BIT`, 1, index of isLd in the control word
- `WB_BIT`, 6, index of isWb in the control word
- `TIMEOUT`, 16, maximum REQ cycles to wait for `dmem_ack`
- `NOP_INSN`, 32'h6800_0000, instruction word emitted for bubbles

Ports:
- `clk`  in  1  clock; all state updates on the rising edge
- `rst`  in  1  synchronous, active-low reset
- `pc`  in  32  PC from EX/MA
- `aluresult`  in  32  ALU result from EX/MA; also the memory address
- `op2`  in  32  store data from EX/MA
- `instruction`  in  32  instruction word from EX/MA
- `control`  in  22  control word from EX/MA
- `dmem_req`  out  1  memory request, held until ack or timeout
- `dmem_we`  out  1  1 = store, 0 = load
- `dmem_addr`  out  32  word address
- `dmem_wdata`  out  32  store data
- `dmem_ack`  in  1  memory completion, one-cycle pulse
- `dmem_rdata`  in  32  load data, valid when `dmem_ack`=1
- `pc_o`  out  32  PC to MA/RW
- `ldresult_o`  out  32  load result to MA/RW
- `aluresult_o`  out  32  ALU result to MA/RW
- `instruction_o`  out  32  instruction word to MA/RW
- `control_o`  out  22  control word to MA/RW
- `stall`  out  1  freeze IF/OF/EX and the EX/MA register
- `misalign_err`  out  1  sticky misaligned-access flag
- `bus_err`  out  1  sticky memory-timeout flag

## Operation
- A memory op (memop) is `control[LD_BIT] | control[ST_BIT]`.
- FSM states: IDLE, REQ, DONE.
- IDLE, non-memop:
  - Combinational pass-through of `pc`, `aluresult`, `instruction`, `control`.
  - `ldresult_o` = 0, `stall` = 0.
- IDLE, memop with `aluresult[1:0]` != 0:
  - No request is issued; `stall` = 0.
  - Pass-through, but `control_o` has the LD, ST and WB bits cleared.
  - `misalign_err` is set at the next edge.
- IDLE, aligned memop:
  - `stall` = 1 and the outputs are a bubble.
  - At the edge: register `dmem_addr` = `aluresult`, `dmem_we` = isSt, `dmem_wdata` = `op2`; set `dmem_req` = 1; clear the counter; go to REQ.
- REQ:
  - `stall` = 1, outputs are a bubble, `dmem_req` = 1.
  - The counter increments each cycle.
  - On `dmem_ack` = 1: latch `dmem_rdata` for a load (0 for a store), drop `dmem_req`, go to DONE.
  - If the counter reaches `TIMEOUT` without an ack: latch 32'hDEAD_BEEF, drop `dmem_req`, set `bus_err`, go to DONE.
  - If the ack and the timeout fall in the same cycle, the ack wins.
- DONE:
  - `stall` = 0.
  - Outputs are the held EX/MA fields with `ldresult_o` = the latched value.
  - Go to IDLE unconditionally; the instruction is never re-detected.
- Bubble definition: `pc_o` = 0, `ldresult_o` = 0, `aluresult_o` = 0, `instruction_o` = `NOP_INSN`, `control_o` = 0.
- `dmem_ack` is ignored outside REQ.
- `misalign_err` and `bus_err` clear only on reset.

## Timing
- Reset (`rst` = 0 at an edge) sets:
  - state = IDLE
  - `dmem_req` = 0, `dmem_we` = 0, `dmem_addr` = 0, `dmem_wdata` = 0
  - counter = 0, latched data = 0
  - `misalign_err` = 0, `bus_err` = 0
- After reset, outputs follow the IDLE rules against the current inputs.
- Reset during REQ: `dmem_req` drops at that edge; a later ack is ignored.
- Non-memop and misaligned: zero added latency, no stall.
- Aligned access with the ack in the k-th REQ cycle (k ≥ 1):
  - `stall` is high for 1+k cycles.
  - The result appears on the outputs in cycle 2+k after the instruction arrived and is captured by MA/RW at the end of that cycle.
- Timeout: `stall` is high for 1+`TIMEOUT` cycles, then DONE.
- Back-to-back memops: the second is detected in the IDLE cycle that follows DONE.

## Test plan
- **Reset:** hold `rst`=0 for 2 cycles with a memop present → `dmem_req`=0, both error flags 0. Release → `dmem_req` rises at the first active edge.
- **ALU pass-through:** non-memop with `aluresult`=32'h0000_0123 → same cycle `aluresult_o`=32'h123, `ldresult_o`=0, `stall`=0.
- **Load, ack after 3 cycles:**
  - Stimulus: ld, addr 32'h40; `dmem_ack`=1 with `dmem_rdata`=32'hCAFE_F00D in the 3rd REQ cycle.
  - Response: `stall` high for 4 cycles, bubbles with `instruction_o`=32'h6800_0000, then one DONE cycle with `ldresult_o`=32'hCAFE_F00D.
- **Store, immediate ack:**
  - Stimulus: st, addr 32'h80, `op2`=32'h1234; ack in the 1st REQ cycle.
  - Response: `dmem_we`=1, `dmem_wdata`=32'h1234, `stall` high for 2 cycles, `ldresult_o`=0 in DONE.
- **Misaligned load:** ld with addr 32'h42 → no `dmem_req`, `stall`=0, `control_o` LD/ST/WB bits = 0, `misalign_err`=1 from the next edge on.
- **Timeout, then late ack:**
  - Stimulus: ld with `TIMEOUT`=16 and no ack; an ack arrives during the following IDLE cycle.
  - Response: `bus_err`=1, `ldresult_o`=32'hDEAD_BEEF in DONE after 17 stall cycles; the late ack is ignored.

Source files
------------

// File: rtl/ma_stage.sv
// TinyRISC memory-access stage: issues loads/stores over a req/ack handshake,
// stalls upstream while an access is outstanding and flags misalignment/timeouts.
module ma_stage #(
  parameter int          ST_BIT   = 0,
  parameter int          LD_BIT   = 1,
  parameter int          WB_BIT   = 6,
  parameter int          TIMEOUT  = 16,
  parameter logic [31:0] NOP_INSN = 32'h6800_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] pc,
  input  logic [31:0] aluresult,
  input  logic [31:0] op2,
  input  logic [31:0] instruction,
  input  logic [21:0] control,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  input  logic        dmem_ack,
  input  logic [31:0] dmem_rdata,
  output logic [31:0] pc_o,
  output logic [31:0] ldresult_o,
  output logic [31:0] aluresult_o,
  output logic [31:0] instruction_o,
  output logic [21:0] control_o,
  output logic        stall,
  output logic        misalign_err,
  output logic        bus_err
);

  localparam int CW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [CW-1:0] r_cnt;
  logic [CW-1:0] w_cnt_inc;
  logic [31:0] r_ldata;
  logic        r_dmem_req;
  logic        r_dmem_we;
  logic [31:0] r_dmem_addr;
  logic [31:0] r_dmem_wdata;
  logic        r_misalign_err;
  logic        r_bus_err;
  logic        w_memop;
  logic        w_unaligned;
  logic        w_issue;
  logic        w_misalign;
  logic        w_ack;
  logic        w_timeout;
  logic [21:0] w_mem_mask;

  assign w_memop     = control[LD_BIT] | control[ST_BIT];
  assign w_unaligned = (aluresult[1:0] != 2'b00);
  assign w_cnt_inc   = r_cnt + CW'(1);
  assign w_mem_mask  = (22'd1 << LD_BIT) | (22'd1 << ST_BIT) | (22'd1 << WB_BIT);

  assign dmem_req     = r_dmem_req;
  assign dmem_we      = r_dmem_we;
  assign dmem_addr    = r_dmem_addr;
  assign dmem_wdata   = r_dmem_wdata;
  assign misalign_err = r_misalign_err;
  assign bus_err      = r_bus_err;

  // Next-state selection and the stage outputs (pass-through, bubble or result).
  always_comb begin
    w_state_nxt   = r_state;
    stall         = 1'b0;
    pc_o          = pc;
    aluresult_o   = aluresult;
    instruction_o = instruction;
    control_o     = control;
    ldresult_o    = 32'h0000_0000;
    w_issue       = 1'b0;
    w_misalign    = 1'b0;
    w_ack         = 1'b0;
    w_timeout     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_memop && w_unaligned) begin
          // Misaligned ops retire as harmless no-ops: no memory, no writeback.
          control_o  = control & ~w_mem_mask;
          w_misalign = 1'b1;
        end else if (w_memop) begin
          stall         = 1'b1;
          pc_o          = 32'h0000_0000;
          aluresult_o   = 32'h0000_0000;
          instruction_o = NOP_INSN;
          control_o     = 22'h00_0000;
          w_issue       = 1'b1;
          w_state_nxt   = S_REQ;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_REQ: begin
        stall         = 1'b1;
        pc_o          = 32'h0000_0000;
        aluresult_o   = 32'h0000_0000;
        instruction_o = NOP_INSN;
        control_o     = 22'h00_0000;
        if (dmem_ack) begin
          w_ack       = 1'b1;
          w_state_nxt = S_DONE;
        end else if (w_cnt_inc == CW'(TIMEOUT)) begin
          w_timeout   = 1'b1;
          w_state_nxt = S_DONE;
        end else begin
          w_state_nxt = S_REQ;
        end
      end
      S_DONE: begin
        ldresult_o  = r_ldata;
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Memory request, wait counter, latched load data and sticky error flags.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_dmem_req     <= 1'b0;
      r_dmem_we      <= 1'b0;
      r_dmem_addr    <= 32'h0000_0000;
      r_dmem_wdata   <= 32'h0000_0000;
      r_cnt          <= '0;
      r_ldata        <= 32'h0000_0000;
      r_misalign_err <= 1'b0;
      r_bus_err      <= 1'b0;
    end else begin
      if (w_issue) begin
        r_dmem_req   <= 1'b1;
        r_dmem_we    <= control[ST_BIT];
        r_dmem_addr  <= aluresult;
        r_dmem_wdata <= op2;
        r_cnt        <= '0;
      end else if (r_state == S_REQ) begin
        r_cnt <= w_cnt_inc;
        if (w_ack) begin
          r_dmem_req <= 1'b0;
          r_ldata    <= r_dmem_we ? 32'h0000_0000 : dmem_rdata;
        end else if (w_timeout) begin
          r_dmem_req <= 1'b0;
          r_ldata    <= 32'hDEAD_BEEF;
          r_bus_err  <= 1'b1;
        end else begin
          r_dmem_req <= 1'b1;
        end
      end else begin
        r_cnt <= r_cnt;
      end
      if (w_misalign) begin
        r_misalign_err <= 1'b1;
      end else begin
        r_misalign_err <= r_misalign_err;
      end
    end
  end

endmodule

// File: tb/tb_ma_stage.sv
// Scoreboard bench for ma_stage: stimulus queues the expected MA/RW word,
// a negedge monitor checks bubbles while stalled and pops on each retiring cycle.
module tb_ma_stage;

  localparam logic [31:0] NOP = 32'h6800_0000;
  localparam int          TO  = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] pc, aluresult, op2, instruction;
  logic [21:0] control;
  logic        dmem_req, dmem_we, dmem_ack;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic [31:0] pc_o, ldresult_o, aluresult_o, instruction_o;
  logic [21:0] control_o;
  logic        stall, misalign_err, bus_err;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] ld;
    logic [31:0] alu;
    logic [31:0] ins;
    logic [21:0] ctl;
    int          stalls;
  } exp_t;

  exp_t q[$];
  int   n_chk  = 0;
  int   n_pass = 0;
  int   stall_cnt = 0;
  logic mon_en = 1'b0;

  ma_stage #(.TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .pc(pc), .aluresult(aluresult), .op2(op2),
    .instruction(instruction), .control(control),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata), .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
    .pc_o(pc_o), .ldresult_o(ldresult_o), .aluresult_o(aluresult_o),
    .instruction_o(instruction_o), .control_o(control_o), .stall(stall),
    .misalign_err(misalign_err), .bus_err(bus_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
  endtask

  // Monitor: bubbles while stalled, scoreboard pop on every non-stalled cycle.
  always @(negedge clk) begin
    if (mon_en) begin
      if (stall === 1'b1) begin
        stall_cnt++;
        chk("bubble_pc", pc_o, 32'h0);
        chk("bubble_alu", aluresult_o, 32'h0);
        chk("bubble_ins", instruction_o, NOP);
        chk("bubble_ctl", {10'h0, control_o}, 32'h0);
        if (stall_cnt > 40) begin
          chk("stall_bound", 32'(stall_cnt), 32'd40);
          stall_cnt = 0;
        end
      end else if (q.size() == 0) begin
        chk("unexpected_output", 32'(q.size()), 32'd1);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("stall_cycles", 32'(stall_cnt), 32'(e.stalls));
        chk("pc_o", pc_o, e.pc);
        chk("ldresult_o", ldresult_o, e.ld);
        chk("aluresult_o", aluresult_o, e.alu);
        chk("instruction_o", instruction_o, e.ins);
        chk("control_o", {10'h0, control_o}, {10'h0, e.ctl});
        stall_cnt = 0;
      end
    end
  end

  // Non-memop or misaligned op: retires in the same cycle, no stall.
  task automatic do_pass(input logic [31:0] p, input logic [31:0] ins, input logic [21:0] ctl,
                         input logic [31:0] alu, input logic [21:0] exp_ctl);
    exp_t e;
    pc = p; instruction = ins; control = ctl; aluresult = alu; op2 = 32'h5555_AAAA;
    e.pc = p; e.ld = 32'h0; e.alu = alu; e.ins = ins; e.ctl = exp_ctl; e.stalls = 0;
    q.push_back(e);
    @(posedge clk); #1;
    chk("no_req", {31'h0, dmem_req}, 32'h0);
  endtask

  // Aligned access; ack_cyc = 0 means no ack (timeout).
  task automatic do_access(input logic [31:0] p, input logic [31:0] ins, input logic [21:0] ctl,
                           input logic [31:0] addr, input logic [31:0] wd, input int ack_cyc,
                           input logic [31:0] rd, input logic [31:0] exp_ld, input logic exp_we);
    exp_t e;
    int   n;
    pc = p; instruction = ins; control = ctl; aluresult = addr; op2 = wd;
    n = (ack_cyc == 0) ? TO : ack_cyc;
    e.pc = p; e.ld = exp_ld; e.alu = addr; e.ins = ins; e.ctl = ctl; e.stalls = 1 + n;
    q.push_back(e);
    @(posedge clk); #1;
    chk("req_up", {31'h0, dmem_req}, 32'h1);
    chk("dmem_we", {31'h0, dmem_we}, {31'h0, exp_we});
    chk("dmem_addr", dmem_addr, addr);
    chk("dmem_wdata", dmem_wdata, wd);
    for (int c = 1; c <= n; c++) begin
      if (c == ack_cyc) begin
        dmem_ack = 1'b1; dmem_rdata = rd;
      end
      @(posedge clk); #1;
      dmem_ack = 1'b0; dmem_rdata = 32'h0BAD_0BAD;
    end
    chk("req_down", {31'h0, dmem_req}, 32'h0);
    @(posedge clk); #1;
  endtask

  initial begin
    rst = 1'b0; dmem_ack = 1'b0; dmem_rdata = 32'h0;
    pc = 32'h100; instruction = 32'hA000_0001; control = 22'h442;
    aluresult = 32'h40; op2 = 32'h0;
    @(posedge clk); @(posedge clk); #1;
    chk("rst_req", {31'h0, dmem_req}, 32'h0);
    chk("rst_misalign", {31'h0, misalign_err}, 32'h0);
    chk("rst_buserr", {31'h0, bus_err}, 32'h0);
    rst = 1'b1; mon_en = 1'b1;
    // Load held across reset release, ack in the 3rd REQ cycle.
    do_access(32'h100, 32'hA000_0001, 22'h442, 32'h40, 32'h0, 3, 32'hCAFE_F00D, 32'hCAFE_F00D, 1'b0);
    // ALU pass-through.
    do_pass(32'h104, 32'h1234_5678, 22'h0C0, 32'h0000_0123, 22'h0C0);
    // Store, immediate ack, back-to-back with a following load.
    do_access(32'h108, 32'hB000_0002, 22'h801, 32'h80, 32'h1234, 1, 32'hFFFF_FFFF, 32'h0, 1'b1);
    do_access(32'h10C, 32'hA000_0003, 22'h442, 32'h84, 32'h0, 2, 32'h0000_7777, 32'h0000_7777, 1'b0);
    chk("misalign_before", {31'h0, misalign_err}, 32'h0);
    // Misaligned load.
    do_pass(32'h110, 32'hA000_0004, 22'h442, 32'h42, 22'h400);
    chk("misalign_set", {31'h0, misalign_err}, 32'h1);
    chk("buserr_before", {31'h0, bus_err}, 32'h0);
    // Timeout, then a late ack during the following IDLE cycle.
    do_access(32'h114, 32'hA000_0005, 22'h442, 32'h100, 32'h0, 0, 32'h0, 32'hDEAD_BEEF, 1'b0);
    chk("buserr_set", {31'h0, bus_err}, 32'h1);
    dmem_ack = 1'b1; dmem_rdata = 32'h1111_2222;
    do_pass(32'h118, 32'h2222_0000, 22'h040, 32'h0000_0ABC, 22'h040);
    dmem_ack = 1'b0;
    do_pass(32'h11C, 32'h3333_0000, 22'h000, 32'h0000_0DEF, 22'h000);
    chk("buserr_sticky", {31'h0, bus_err}, 32'h1);
    chk("misalign_sticky", {31'h0, misalign_err}, 32'h1);
    mon_en = 1'b0;
    chk("queue_empty", 32'(q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
